// File: rtl/sgd_data_loader_if.sv
// Word-stream handshake into the SGD data loader.
// Master drives words, slave returns ready.
interface sgd_data_loader_if #(
  parameter int LENGTH = 16
);
  logic              s_valid;
  logic              s_ready;
  logic              s_last;
  logic [LENGTH-1:0] s_data;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready
  );
endinterface

// File: rtl/sgd_data_loader.sv
// Packs a serial word stream into rows, stores them, serves rows on a shared bus.
// Optional stream checksum enabled by SGD_LOADER_CKSUM_EN.
module sgd_data_loader #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int LENGTH       = 16,
  parameter int DATA_WIDTH   = LENGTH*(MAX_FEATURES+1),
  parameter int DP           = 1024
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  load_start,
  input  logic [3:0]            feat,
  sgd_data_loader_if.slave      s,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH-1:0] data_points,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  core_done,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic [LENGTH-1:0]     cksum
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] SERVE  = 2'd3;

  localparam int RAW = $clog2(DP+1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            feat_q, feat_d;
  logic [3:0]            widx_q, widx_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [ADDR_WIDTH-1:0] dp_q, dp_d;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic                  acc, we, full;

  logic [DATA_WIDTH-1:0] ram_q [DP+1];

  assign s.s_ready   = state_q == FILL;
  assign acc         = s.s_valid && s.s_ready && !load_start;
  assign full        = row_q == ADDR_WIDTH'(DP);
  assign we          = state_q == COMMIT && !load_start;
  assign busy        = state_q == FILL || state_q == COMMIT;
  assign load_done   = state_q == SERVE;
  assign load_err    = err_q;
  assign data_points = dp_q;

  always_comb begin
    state_d = state_q;
    feat_d  = feat_q;
    widx_d  = widx_q;
    row_d   = row_q;
    dp_d    = dp_q;
    buf_d   = buf_q;
    last_d  = last_q;
    err_d   = err_q;
    if (load_start) begin
      state_d = FILL;
      feat_d  = feat;
      widx_d  = '0;
      row_d   = '0;
      dp_d    = '0;
      buf_d   = '0;
      last_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (acc) begin
            for (int k = 0; k <= MAX_FEATURES; k++)
              if (widx_q == 4'(k))
                buf_d[DATA_WIDTH-1-LENGTH*k -: LENGTH] = s.s_data;
            if (s.s_last || widx_q == feat_q) begin
              state_d = COMMIT;
              last_d  = s.s_last;
              if (s.s_last && widx_q != feat_q)
                err_d = 1'b1;
            end else begin
              widx_d = widx_q + 4'd1;
            end
          end
        end
        COMMIT: begin
          row_d  = row_q + 1'b1;
          buf_d  = '0;
          widx_d = '0;
          last_d = 1'b0;
          if (last_q || full) begin
            state_d = SERVE;
            dp_d    = row_q;
            if (!last_q)
              err_d = 1'b1;
          end else begin
            state_d = FILL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      feat_q  <= '0;
      widx_q  <= '0;
      row_q   <= '0;
      dp_q    <= '0;
      buf_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      feat_q  <= feat_d;
      widx_q  <= widx_d;
      row_q   <= row_d;
      dp_q    <= dp_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
      err_q   <= err_d;
      raddr_q <= rd_addr;
    end
  end

  // Dataset storage is deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (we)
      ram_q[row_q[RAW-1:0]] <= buf_q;
  end

  assign rdata = (raddr_q < row_q) ? ram_q[raddr_q[RAW-1:0]] : '0;

  assign data = (state_q == SERVE && !core_done) ? rdata
                                                 : {DATA_WIDTH{1'bz}};

`ifdef SGD_LOADER_CKSUM_EN
  logic [LENGTH-1:0] cks_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      cks_q <= '0;
    else if (load_start)
      cks_q <= '0;
    else if (acc)
      cks_q <= cks_q + s.s_data;
  end

  assign cksum = cks_q;
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_sgd_data_loader.sv
// Scoreboard bench for sgd_data_loader (DP overridden to 4).
// Checks reset, packing, truncation, overflow, bus release, restart, checksum.
module tb_sgd_data_loader;

  localparam int AW = 12;
  localparam int DW = 256;
  localparam logic [DW-1:0] PAT = 256'h00A5;
`ifdef SGD_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic [3:0]    feat = '0;
  logic          busy, load_done, load_err;
  logic [AW-1:0] data_points;
  logic [AW-1:0] rd_addr = '0;
  logic          core_done = 1'b0;
  logic [15:0]   cksum;
  logic          drv_en = 1'b0;
  wire  [DW-1:0] data;

  assign data = drv_en ? PAT : {DW{1'bz}};

  sgd_data_loader_if #(.LENGTH(16)) sif ();

  sgd_data_loader #(.DP(4)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .load_start (load_start),
    .feat       (feat),
    .s          (sif),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err),
    .data_points(data_points),
    .rd_addr    (rd_addr),
    .core_done  (core_done),
    .data       (data),
    .cksum      (cksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    int            sel;
    logic [DW-1:0] exp;
  } item_t;

  item_t sbq[$];
  int n_chk = 0;
  int n_fail = 0;
  logic req = 1'b0;
  logic req_q = 1'b0;

  function automatic logic [DW-1:0] row4(
    input logic [15:0] a, b, c, d);
    return {a, b, c, d, 192'b0};
  endfunction

  function automatic logic [DW-1:0] actual(input int sel);
    case (sel)
      0: return data;
      1: return DW'(load_done);
      2: return DW'(data_points);
      3: return DW'(load_err);
      4: return DW'(sif.s_ready);
      5: return DW'(busy);
      default: return DW'(cksum);
    endcase
  endfunction

  task automatic cmp(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) req_q <= req;

  always @(negedge clk) begin
    item_t it;
    if (req_q) begin
      while (sbq.size() > 0) begin
        it = sbq.pop_front();
        cmp(it.name, actual(it.sel), it.exp);
      end
    end
  end

  task automatic expect_(input string name, input int sel,
                         input logic [DW-1:0] exp);
    sbq.push_back('{name, sel, exp});
  endtask

  task automatic flush();
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    #1;
  endtask

  task automatic rd(input string name, input logic [AW-1:0] a,
                    input logic [DW-1:0] exp);
    @(negedge clk);
    rd_addr = a;
    expect_(name, 0, exp);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    #1;
  endtask

  task automatic start(input logic [3:0] f);
    @(negedge clk);
    load_start = 1'b1;
    feat = f;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input bit last,
                      output bit ok);
    int n;
    n = 0;
    sif.s_valid = 1'b1;
    sif.s_data = d;
    sif.s_last = last;
    while (!sif.s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = sif.s_ready;
    @(negedge clk);
    sif.s_valid = 1'b0;
    sif.s_last = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!load_done && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int nacc;
    sif.s_valid = 1'b0;
    sif.s_data = '0;
    sif.s_last = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset mid-FILL
    start(4'd2);
    send(16'h1234, 1'b0, ok);
    expect_("busy_fill", 5, 1);
    flush();
    @(negedge clk);
    rst_n = 1'b0;
    drv_en = 1'b1;
    expect_("rst_s_ready", 4, 0);
    expect_("rst_busy", 5, 0);
    expect_("rst_load_done", 1, 0);
    expect_("rst_load_err", 3, 0);
    expect_("rst_data_points", 2, 0);
    expect_("rst_cksum", 6, 0);
    expect_("rst_data_z", 0, PAT);
    flush();
    rst_n = 1'b1;
    drv_en = 1'b0;
    expect_("idle_s_ready", 4, 0);
    expect_("idle_busy", 5, 0);
    flush();

    // main load, feat=2
    start(4'd2);
    send(16'h0100, 0, ok); send(16'h0080, 0, ok); send(16'hFF80, 0, ok);
    send(16'h0200, 0, ok); send(16'h0010, 0, ok); send(16'h0020, 0, ok);
    send(16'h0300, 0, ok); send(16'h0030, 0, ok); send(16'h0040, 1, ok);
    wait_done();
    expect_("main_load_done", 1, 1);
    expect_("main_data_points", 2, 2);
    expect_("main_load_err", 3, 0);
    expect_("main_busy", 5, 0);
    expect_("main_s_ready", 4, 0);
    expect_("main_cksum", 6, CK ? DW'(16'h06A0) : '0);
    flush();
    rd("main_row1", 1, row4(16'h0200, 16'h0010, 16'h0020, 0));
    rd("main_row2", 2, row4(16'h0300, 16'h0030, 16'h0040, 0));
    rd("main_row3_oob", 3, '0);
    rd("main_row0", 0, row4(16'h0100, 16'h0080, 16'hFF80, 0));

    // bus release while row 0 is addressed
    drv_en = 1'b1;
    core_done = 1'b1;
    #1 cmp("bus_release_now", data, PAT);
    expect_("bus_release", 0, PAT);
    flush();
    core_done = 1'b0;
    drv_en = 1'b0;
    #1 cmp("bus_redrive", data, row4(16'h0100, 16'h0080, 16'hFF80, 0));

    // truncation, feat=3
    start(4'd3);
    send(16'h0001, 0, ok); send(16'h0002, 0, ok);
    send(16'h0003, 0, ok); send(16'h0004, 0, ok);
    send(16'h0011, 0, ok); send(16'h0012, 1, ok);
    wait_done();
    expect_("trunc_load_done", 1, 1);
    expect_("trunc_load_err", 3, 1);
    expect_("trunc_data_points", 2, 1);
    expect_("trunc_cksum", 6, CK ? DW'(16'h002D) : '0);
    flush();
    rd("trunc_row1", 1, row4(16'h0011, 16'h0012, 0, 0));
    rd("trunc_row0", 0, row4(16'h0001, 16'h0002, 16'h0003, 16'h0004));
    rd("trunc_row2_stale", 2, '0);

    // overflow, 7 rows offered with DP=4
    start(4'd2);
    nacc = 0;
    ok = 1'b1;
    for (int r = 0; r < 7 && ok; r++)
      for (int k = 0; k < 3 && ok; k++) begin
        send(16'((r << 8) | (k + 1)), 1'b0, ok);
        if (ok) nacc++;
      end
    cmp("ovf_words_accepted", DW'(nacc), DW'(15));
    expect_("ovf_s_ready", 4, 0);
    expect_("ovf_load_done", 1, 1);
    expect_("ovf_load_err", 3, 1);
    expect_("ovf_data_points", 2, 4);
    expect_("ovf_cksum", 6, CK ? DW'(16'h1E1E) : '0);
    flush();
    rd("ovf_row4", 4, row4(16'h0401, 16'h0402, 16'h0403, 0));
    rd("ovf_row5", 5, '0);

    // feat=0 and checksum wrap
    start(4'd0);
    send(16'hFFFF, 0, ok);
    send(16'h0002, 1, ok);
    wait_done();
    expect_("f0_data_points", 2, 1);
    expect_("f0_load_err", 3, 0);
    expect_("f0_cksum", 6, CK ? DW'(16'h0001) : '0);
    flush();
    rd("f0_row0", 0, row4(16'hFFFF, 0, 0, 0));
    rd("f0_row1", 1, row4(16'h0002, 0, 0, 0));

    // restart from SERVE, mid-FILL, and with a colliding word
    start(4'd1);
    expect_("rs_load_done", 1, 0);
    expect_("rs_busy", 5, 1);
    flush();
    send(16'hAAAA, 0, ok);
    @(negedge clk);
    load_start = 1'b1;
    feat = 4'd1;
    sif.s_valid = 1'b1;
    sif.s_data = 16'hBBBB;
    @(negedge clk);
    load_start = 1'b0;
    sif.s_valid = 1'b0;
    send(16'h0005, 0, ok);
    send(16'h0006, 1, ok);
    wait_done();
    expect_("rs_done", 1, 1);
    expect_("rs_data_points_sat", 2, 0);
    expect_("rs_load_err", 3, 0);
    expect_("rs_cksum", 6, CK ? DW'(16'h000B) : '0);
    flush();
    rd("rs_row0", 0, row4(16'h0005, 16'h0006, 0, 0));
    rd("rs_row1_oob", 1, '0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
